// File: rtl/l1_trigger_record_fifo.sv
// Timestamps L1 beam triggers, applies a programmable holdoff and queues 64-bit
// records in a first-word-fall-through FIFO drained over an AXI4-Stream master.
module l1_trigger_record_fifo #(
    parameter int NBEAMS          = 2,
    parameter int HOLDOFF_BITS    = 8,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       enable_i,
    input  logic                       clear_i,
    input  logic [HOLDOFF_BITS-1:0]    holdoff_i,
    input  logic [NBEAMS-1:0]          trig_i,
    output logic [63:0]                rec_tdata,
    output logic                       rec_tvalid,
    input  logic                       rec_tready,
    output logic [FIFO_DEPTH_LOG2:0]   fill_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_count_o
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_LVL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        ARMED   = 1'b0,
        HOLDOFF = 1'b1
    } hold_state_t;

    hold_state_t                 state, state_nxt;
    logic [HOLDOFF_BITS-1:0]     hc, hc_nxt;
    logic                        accept;
    logic [47:0]                 ts;

    logic [63:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr, rd_ptr, rd_ptr_inc;
    logic [FIFO_DEPTH_LOG2:0]    fill_nxt;
    logic [63:0]                 rec_word, head_nxt;
    logic                        full, push, pop, drop;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ts <= '0;
        end else begin
            ts <= ts + 48'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ARMED;
            hc    <= '0;
        end else begin
            state <= state_nxt;
            hc    <= hc_nxt;
        end
    end

    // The holdoff runs independently of enable_i and clear_i.
    always_comb begin
        state_nxt = state;
        hc_nxt    = hc;
        accept    = 1'b0;
        case (state)
            ARMED: begin
                if (enable_i && |trig_i) begin
                    accept = 1'b1;
                    hc_nxt = holdoff_i;
                    if (holdoff_i != '0) begin
                        state_nxt = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                hc_nxt = hc - 1'b1;
                if (hc == HOLDOFF_BITS'(1)) begin
                    state_nxt = ARMED;
                end
            end
            default: begin
                state_nxt = ARMED;
                hc_nxt    = '0;
            end
        endcase
    end

    // Fullness is judged before any same-cycle pop, so a full FIFO drops.
    assign full       = (fill_o == FULL_LVL);
    assign pop        = rec_tvalid && rec_tready;
    assign push       = accept && !full && !clear_i;
    assign drop       = accept && full && !clear_i;
    assign rec_word   = {ts, 16'(trig_i)};
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign fill_nxt   = fill_o + (FIFO_DEPTH_LOG2 + 1)'(push)
                               - (FIFO_DEPTH_LOG2 + 1)'(pop);

    // The head word is kept in a register so rec_tdata is driven from a flop.
    always_comb begin
        head_nxt = rec_tdata;
        if (fill_nxt == '0) begin
            head_nxt = '0;
        end else if (fill_o == '0 || (pop && fill_o == (FIFO_DEPTH_LOG2 + 1)'(1))) begin
            head_nxt = rec_word;
        end else if (pop) begin
            head_nxt = mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= rec_word;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_o       <= '0;
            rec_tvalid   <= 1'b0;
            rec_tdata    <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (clear_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_o       <= '0;
            rec_tvalid   <= 1'b0;
            rec_tdata    <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            fill_o     <= fill_nxt;
            rec_tvalid <= (fill_nxt != '0);
            rec_tdata  <= head_nxt;
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_count_o != 16'hFFFF) begin
                    drop_count_o <= drop_count_o + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/l1_trigger_record_fifo.md
# l1_trigger_record_fifo

Downstream consumer of the L1 beam-trigger vector produced by the L1 trigger wrapper, in the same `aclk` domain. It timestamps each trigger and applies a programmable holdoff. Each accepted trigger is queued as a 64-bit record in a small FIFO and drained over an AXI4-Stream master with full `tready` back-pressure. It also keeps a sticky overflow flag and a saturating count of dropped triggers for software readback.

## Interface
Parameters:
- `NBEAMS`, 2: width of the trigger vector; legal range 1..16.
- `HOLDOFF_BITS`, 8: width of the holdoff setting.
- `FIFO_DEPTH_LOG2`, 4: FIFO depth is 2^FIFO_DEPTH_LOG2 records.

Ports:
- Clock and reset: one clock, `aclk`; reset `aresetn` is asynchronous and active-low.
- `aclk` in 1: single clock for all logic.
- `aresetn` in 1: asynchronous, active-low reset.
- `enable_i` in 1: when 0, no triggers are accepted. Holdoff keeps counting down.
- `clear_i` in 1: synchronous flush of the FIFO, overflow flag and drop count.
- `holdoff_i` in HOLDOFF_BITS: number of dead cycles after an accepted trigger.
- `trig_i` in NBEAMS: per-beam trigger, sampled every cycle.
- `rec_tdata` out 64: record. Bits [63:16] = timestamp; bits [15:NBEAMS] = 0; bits [NBEAMS-1:0] = beam mask.
- `rec_tvalid` out 1: record available.
- `rec_tready` in 1: sink accepts the record.
- `fill_o` out FIFO_DEPTH_LOG2+1: current FIFO occupancy.
- `overflow_o` out 1: sticky; a trigger was dropped because the FIFO was full.
- `drop_count_o` out 16: saturating count of dropped triggers.

## Operation
- Timestamp: 48-bit free-running counter.
  - Reads 0 in the first cycle after reset deasserts, then increments every cycle.
  - Wraps from 2^48-1 to 0.
  - Not affected by `clear_i`.
- Holdoff FSM, two states, tracked by holdoff counter `hc`:
  - ARMED (`hc`==0): if `enable_i` && |`trig_i`, the trigger is accepted. Record = {timestamp of that cycle, `trig_i` of that cycle}. `hc` loads `holdoff_i`. If `holdoff_i`≠0, go to HOLDOFF; otherwise stay ARMED.
  - HOLDOFF (`hc`≠0): `trig_i` is ignored and not counted. `hc` decrements each cycle and the FSM returns to ARMED when it reaches 0.
  - Result: with holdoff H, the next accept is no earlier than H+1 cycles after the previous one. With H=0, a trigger can be accepted every cycle.
  - A level held on `trig_i` re-triggers once per H+1 cycles. No edge detection is performed.
- Accepted trigger, FIFO not full: the record is pushed.
- Accepted trigger, FIFO full:
  - The record is dropped, `overflow_o` is set, and `drop_count_o` increments, saturating at 0xFFFF.
  - Fullness is evaluated before any same-cycle pop. A push when full is dropped even if `rec_tready` pops in that cycle.
  - Holdoff still restarts.
- Output stream:
  - First-word-fall-through. `rec_tvalid` = FIFO non-empty.
  - A pop occurs on `rec_tvalid` && `rec_tready`.
  - While `rec_tvalid` && !`rec_tready`, `rec_tdata` is held stable.
  - `rec_tvalid` never deasserts without a handshake, except on `clear_i` or reset.
  - Records leave in acceptance order.
- `clear_i`:
  - Empties the FIFO and zeroes `overflow_o` and `drop_count_o` in the next cycle.
  - Has priority over a same-cycle push and pop; a trigger accepted in the clear cycle is discarded and not counted.
  - Holdoff FSM and timestamp are unaffected.
- Reset: all state cleared.
  - After reset: `rec_tvalid`=0, `rec_tdata`=0, `fill_o`=0, `overflow_o`=0, `drop_count_o`=0, `hc`=0 (ARMED), timestamp=0.
  - Reset asserted mid-operation discards all queued records immediately.

## Timing
- All outputs are registered.
- Latency: a trigger accepted in cycle t with the FIFO empty gives `rec_tvalid`=1 in cycle t+1, carrying timestamp t.
- `fill_o` reflects the push or pop of cycle t in cycle t+1.
- Simultaneous push and pop when neither empty nor full leaves `fill_o` unchanged.
- The FIFO pointers wrap modulo 2^FIFO_DEPTH_LOG2. Full is `fill_o`==2^FIFO_DEPTH_LOG2.
- Full throughput: with `rec_tready` held at 1, the block sustains one record per cycle with no drops.

## Test plan
- Single trigger: reset, wait 10 cycles, `trig_i`=2'b10 for 1 cycle with `holdoff_i`=0 and `rec_tready`=1 → one record, `rec_tdata`[63:16]=10, [1:0]=2'b10, `rec_tvalid` high for exactly 1 cycle.
- Holdoff: `holdoff_i`=5, `trig_i`=2'b01 held for 20 cycles → records at timestamps t, t+6, t+12, t+18 only.
- Back-pressure and overflow: `rec_tready`=0, `holdoff_i`=0, 20 trigger cycles with depth 16 → `fill_o`=16, `overflow_o`=1, `drop_count_o`=4. Then `rec_tready`=1 → 16 records with consecutive timestamps, in order, data stable while stalled.
- Full with same-cycle pop: FIFO full, `rec_tready`=1 and a trigger in the same cycle → trigger dropped, `drop_count_o`+1, `fill_o`=15.
- Clear and reset: `clear_i` with 8 queued records and a same-cycle trigger → next cycle `fill_o`=0, `rec_tvalid`=0, `drop_count_o`=0, timestamp continues. Assert `aresetn`=0 mid-stream → all outputs 0 immediately, timestamp restarts at 0.
- Enable gating: `enable_i`=0 with `trig_i` active → no records and `drop_count_o` unchanged.
